// File: rtl/mul_digit_feeder_if.sv
// Operand/digit bundle between the digit feeder and its neighbours.
// The master drives the operands and start, and the slave (the feeder) drives the digit stream.
interface mul_digit_feeder_if #(
  parameter int unsigned DIGITS = 32,
  parameter int unsigned M      = 163
);
  logic              start;
  logic [M-1:0]      a;
  logic [M-1:0]      b;
  logic              ready;
  logic [DIGITS-1:0] a_dig;
  logic [DIGITS-1:0] b_dig;
  logic [DIGITS-1:0] g_dig;
  logic              ctr;
  logic              dig_valid;
  logic [2:0]        dig_idx;
  logic              done;

  modport master (
    output start, a, b,
    input  ready, a_dig, b_dig, g_dig, ctr, dig_valid, dig_idx, done
  );

  modport slave (
    input  start, a, b,
    output ready, a_dig, b_dig, g_dig, ctr, dig_valid, dig_idx, done
  );
endinterface

// File: rtl/mul_digit_feeder.sv
// Operand scheduler for the digit-serial multiplier array. It streams padded A, B and G
// most-significant digit first into PE0, waits for the array to flush, and then pulses done.
module mul_digit_feeder #(
  parameter int unsigned   DIGITS    = 32,
  parameter int unsigned   M         = 163,
  parameter int unsigned   NDIG      = 6,
  parameter logic [M-1:0]  POLY      = {{(M-8){1'b0}}, 8'hC9},
  parameter int unsigned   FLUSH_CYC = 12
) (
  input logic               i_clk,
  input logic               i_rst,
  mul_digit_feeder_if.slave io_bus
);

  localparam int unsigned W = NDIG * DIGITS;
  localparam logic [W-1:0] G_PAD = {{(W-M-1){1'b0}}, 1'b1, POLY};
  localparam logic [3:0] STREAM_LAST = 4'(NDIG - 1);
  localparam logic [3:0] FLUSH_LAST  = 4'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {StIdle, StStream, StFlush} state_e;

  state_e            r_state, w_state_d;
  logic [3:0]        r_cnt, w_cnt_d;
  logic [W-1:0]      r_a_pad, r_b_pad;
  logic [W-1:0]      w_a_src, w_b_src, w_a_sh, w_b_sh, w_g_sh;
  logic [DIGITS-1:0] w_a_dig, w_b_dig, w_g_dig;
  logic              w_accept;

  logic              r_ready, r_ctr, r_dig_valid, r_done;
  logic [2:0]        r_dig_idx;
  logic [DIGITS-1:0] r_a_dig, r_b_dig, r_g_dig;

  assign w_accept = (r_state == StIdle) && io_bus.start;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_d = StStream;
          w_cnt_d   = '0;
        end
      end
      StStream: begin
        if (r_cnt == STREAM_LAST) begin
          w_state_d = StFlush;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 4'd1;
        end
      end
      StFlush: begin
        if (r_cnt == FLUSH_LAST) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  // Digit 0 leaves in the accepting cycle, so it is taken straight from the live operands.
  always_comb begin
    w_a_src = w_accept ? {{(W-M){1'b0}}, io_bus.a} : r_a_pad;
    w_b_src = w_accept ? {{(W-M){1'b0}}, io_bus.b} : r_b_pad;
    w_a_sh  = w_a_src << (DIGITS * w_cnt_d);
    w_b_sh  = w_b_src << (DIGITS * w_cnt_d);
    w_g_sh  = G_PAD << (DIGITS * w_cnt_d);
    w_a_dig = '0;
    w_b_dig = '0;
    w_g_dig = '0;
    if (w_state_d == StStream) begin
      w_a_dig = w_a_sh[W-1 -: DIGITS];
      w_b_dig = w_b_sh[W-1 -: DIGITS];
      w_g_dig = w_g_sh[W-1 -: DIGITS];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_a_pad     <= '0;
      r_b_pad     <= '0;
      r_ready     <= 1'b1;
      r_ctr       <= 1'b1;
      r_done      <= 1'b0;
      r_dig_valid <= 1'b0;
      r_dig_idx   <= '0;
      r_a_dig     <= '0;
      r_b_dig     <= '0;
      r_g_dig     <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_accept) begin
        r_a_pad <= w_a_src;
        r_b_pad <= w_b_src;
      end
      r_ready     <= (w_state_d == StIdle);
      r_dig_valid <= (w_state_d == StStream);
      r_ctr       <= !((w_state_d == StStream) && (w_cnt_d == 4'd0));
      r_dig_idx   <= (w_state_d == StStream) ? w_cnt_d[2:0] : 3'd0;
      r_done      <= (r_state == StFlush) && (w_state_d == StIdle);
      r_a_dig     <= w_a_dig;
      r_b_dig     <= w_b_dig;
      r_g_dig     <= w_g_dig;
    end
  end

  assign io_bus.ready     = r_ready;
  assign io_bus.ctr       = r_ctr;
  assign io_bus.done      = r_done;
  assign io_bus.dig_valid = r_dig_valid;
  assign io_bus.dig_idx   = r_dig_idx;
  assign io_bus.a_dig     = r_a_dig;
  assign io_bus.b_dig     = r_b_dig;
  assign io_bus.g_dig     = r_g_dig;

endmodule

// File: tb/tb_mul_digit_feeder.sv
// Self-checking bench for mul_digit_feeder: table vectors, corner sequences and a random run
// compared against an operation-timeline model.
module tb_mul_digit_feeder;
  localparam int NDIG  = 6;
  localparam int FLUSH = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_digit_feeder_if #(.DIGITS(32), .M(163)) u_if ();

  mul_digit_feeder u_dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (u_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // The model tracks the cycle position inside the current operation (-1 = idle).
  int           m_phase = -1;
  logic         m_done  = 1'b0;
  logic [191:0] m_a, m_b;
  logic [191:0] g_pad;

  typedef struct {
    logic [162:0] a;
    logic [162:0] b;
    logic [31:0]  ea[6];
    logic [31:0]  eb[6];
  } vec_t;

  vec_t       tbl[3];
  logic [31:0] eg[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [191:0] t;
    logic         v;
    v = (m_phase >= 0) && (m_phase < NDIG);
    chk("ready", 64'(u_if.ready), 64'(m_phase < 0));
    chk("dig_valid", 64'(u_if.dig_valid), 64'(v));
    chk("ctr", 64'(u_if.ctr), 64'(m_phase != 0));
    chk("done", 64'(u_if.done), 64'(m_done));
    chk("dig_idx", 64'(u_if.dig_idx), v ? 64'(m_phase) : 64'd0);
    t = v ? (m_a >> (32 * (NDIG - 1 - m_phase))) : 192'd0;
    chk("a_dig", 64'(u_if.a_dig), 64'(t[31:0]));
    t = v ? (m_b >> (32 * (NDIG - 1 - m_phase))) : 192'd0;
    chk("b_dig", 64'(u_if.b_dig), 64'(t[31:0]));
    t = v ? (g_pad >> (32 * (NDIG - 1 - m_phase))) : 192'd0;
    chk("g_dig", 64'(u_if.g_dig), 64'(t[31:0]));
  endtask

  task automatic step();
    logic acc;
    acc = u_if.start && (m_phase < 0) && !rst;
    @(posedge clk);
    #1;
    m_done = 1'b0;
    if (rst) begin
      m_phase = -1;
    end else if (acc) begin
      m_phase = 0;
      m_a     = 192'(u_if.a);
      m_b     = 192'(u_if.b);
    end else if (m_phase >= 0) begin
      m_phase++;
      if (m_phase == NDIG + FLUSH) begin
        m_phase = -1;
        m_done  = 1'b1;
      end
    end
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    u_if.start = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  int first_done, second_done, ndone;

  initial begin
    g_pad = (192'd1 << 163) | 192'hC9;
    rst = 1'b1;
    u_if.start = 1'b0;
    u_if.a = '0;
    u_if.b = '0;

    tbl[0].a  = 163'd1;
    tbl[0].b  = 163'd1 << 162;
    tbl[0].ea = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1};
    tbl[0].eb = '{32'h4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[1].a  = {163{1'b1}};
    tbl[1].b  = 163'hDEADBEEF << 64;
    tbl[1].ea = '{32'h7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[1].eb = '{32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
    tbl[2].a  = {3'b110, 160'h11111111_22222222_33333333_44444444_55555555};
    tbl[2].b  = 163'd1;
    tbl[2].ea = '{32'h6, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
    tbl[2].eb = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1};
    eg = '{32'h8, 32'h0, 32'h0, 32'h0, 32'h0, 32'hC9};

    // Reset values
    do_reset();
    chk("rst_ready", 64'(u_if.ready), 64'd1);
    chk("rst_ctr", 64'(u_if.ctr), 64'd1);
    chk("rst_valid", 64'(u_if.dig_valid), 64'd0);
    chk("rst_a_dig", 64'(u_if.a_dig), 64'd0);

    // Table vectors: digit order and polynomial digits
    for (int v = 0; v < 3; v++) begin
      do_reset();
      u_if.a = tbl[v].a;
      u_if.b = tbl[v].b;
      u_if.start = 1'b1;
      for (int j = 0; j < NDIG; j++) begin
        step();
        u_if.start = 1'b0;
        u_if.a = '0;
        u_if.b = '0;
        chk("tbl_a_dig", 64'(u_if.a_dig), 64'(tbl[v].ea[j]));
        chk("tbl_b_dig", 64'(u_if.b_dig), 64'(tbl[v].eb[j]));
        chk("tbl_g_dig", 64'(u_if.g_dig), 64'(eg[j]));
        chk("tbl_ctr", 64'(u_if.ctr), 64'(j != 0));
        chk("tbl_idx", 64'(u_if.dig_idx), 64'(j));
      end
    end

    // Busy: start held high, ops every NDIG+FLUSH+1 cycles
    do_reset();
    u_if.a = 163'h5A5A;
    u_if.b = 163'hA5A5;
    u_if.start = 1'b1;
    first_done = -1;
    second_done = -1;
    for (int t = 1; t <= 40; t++) begin
      step();
      if (u_if.done === 1'b1) begin
        if (first_done < 0) first_done = t;
        else if (second_done < 0) second_done = t;
      end
    end
    u_if.start = 1'b0;
    chk("busy_first_done", 64'(first_done), 64'd19);
    chk("busy_second_done", 64'(second_done), 64'd38);

    // Back-to-back: start only in the done cycle
    do_reset();
    u_if.a = 163'h1234;
    u_if.b = 163'h4321;
    u_if.start = 1'b1;
    step();
    u_if.start = 1'b0;
    ndone = 0;
    for (int t = 0; t < 40 && ndone == 0; t++) begin
      step();
      if (u_if.done === 1'b1) ndone = 1;
    end
    chk("b2b_done_seen", 64'(ndone), 64'd1);
    u_if.a = 163'd1;
    u_if.b = 163'd1 << 162;
    u_if.start = 1'b1;
    step();
    u_if.start = 1'b0;
    chk("b2b_ctr", 64'(u_if.ctr), 64'd0);
    chk("b2b_valid", 64'(u_if.dig_valid), 64'd1);
    chk("b2b_b_dig", 64'(u_if.b_dig), 64'h4);

    // Abort during digit 3
    do_reset();
    u_if.a = 163'hFEED;
    u_if.b = 163'hBEEF;
    u_if.start = 1'b1;
    step();
    u_if.start = 1'b0;
    for (int j = 0; j < 3; j++) step();
    chk("abort_idx", 64'(u_if.dig_idx), 64'd3);
    rst = 1'b1;
    u_if.start = 1'b1;
    step();
    rst = 1'b0;
    u_if.start = 1'b0;
    chk("abort_valid", 64'(u_if.dig_valid), 64'd0);
    chk("abort_ready", 64'(u_if.ready), 64'd1);
    ndone = 0;
    for (int t = 0; t < 30; t++) begin
      step();
      if (u_if.done === 1'b1) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);

    // Random traffic against the model
    do_reset();
    for (int t = 0; t < 800; t++) begin
      u_if.start = ($urandom_range(0, 99) < 30);
      u_if.a = 163'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      u_if.b = 163'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      rst = ($urandom_range(0, 99) < 2);
      step();
    end
    rst = 1'b0;
    u_if.start = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
